id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush.
// Bubble_Count records inserted bubbles and saturates at BUBBLE_SAT.
module id_ex_stage #(
    parameter logic [15:0] BUBBLE_SAT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_RS1,
    input  logic [4:0]  IF_ID_RS2,
    input  logic [4:0]  IF_ID_RD,
    input  logic [63:0] IF_ID_PC,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    input  logic [63:0] Imm,
    input  logic [3:0]  Funct4,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic [1:0]  ALUOp,
    input  logic        Flush,
    output logic [4:0]  ID_EX_RS1,
    output logic [4:0]  ID_EX_RS2,
    output logic [4:0]  ID_EX_RD,
    output logic [63:0] ID_EX_PC,
    output logic [63:0] ID_EX_ReadData1,
    output logic [63:0] ID_EX_ReadData2,
    output logic [63:0] ID_EX_Imm,
    output logic [3:0]  ID_EX_Funct4,
    output logic [1:0]  ID_EX_ALUOp,
    output logic        ID_EX_Branch,
    output logic        ID_EX_MemRead,
    output logic        ID_EX_MemtoReg,
    output logic        ID_EX_MemWrite,
    output logic        ID_EX_ALUSrc,
    output logic        ID_EX_RegWrite,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic [15:0] Bubble_Count
);

    logic hazard;

    // A load writing x0 never stalls; one bubble suffices because it clears ID_EX_MemRead.
    always_comb begin
        hazard = ID_EX_MemRead && (ID_EX_RD != 5'd0) &&
                 ((ID_EX_RD == IF_ID_RS1) || (ID_EX_RD == IF_ID_RS2));
    end

    always_comb begin
        PC_Write    = !hazard || Flush;
        IF_ID_Write = !hazard || Flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ID_EX_RS1       <= '0;
            ID_EX_RS2       <= '0;
            ID_EX_RD        <= '0;
            ID_EX_PC        <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_Imm       <= '0;
            ID_EX_Funct4    <= '0;
            ID_EX_ALUOp     <= '0;
            ID_EX_Branch    <= 1'b0;
            ID_EX_MemRead   <= 1'b0;
            ID_EX_MemtoReg  <= 1'b0;
            ID_EX_MemWrite  <= 1'b0;
            ID_EX_ALUSrc    <= 1'b0;
            ID_EX_RegWrite  <= 1'b0;
            Bubble_Count    <= '0;
        end else if (Flush) begin
            ID_EX_RS1       <= '0;
            ID_EX_RS2       <= '0;
            ID_EX_RD        <= '0;
            ID_EX_PC        <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_Imm       <= '0;
            ID_EX_Funct4    <= '0;
            ID_EX_ALUOp     <= '0;
            ID_EX_Branch    <= 1'b0;
            ID_EX_MemRead   <= 1'b0;
            ID_EX_MemtoReg  <= 1'b0;
            ID_EX_MemWrite  <= 1'b0;
            ID_EX_ALUSrc    <= 1'b0;
            ID_EX_RegWrite  <= 1'b0;
        end else begin
            ID_EX_PC        <= IF_ID_PC;
            ID_EX_ReadData1 <= ReadData1;
            ID_EX_ReadData2 <= ReadData2;
            ID_EX_Imm       <= Imm;
            ID_EX_Funct4    <= Funct4;
            if (hazard) begin
                ID_EX_RS1       <= '0;
                ID_EX_RS2       <= '0;
                ID_EX_RD        <= '0;
                ID_EX_ALUOp     <= '0;
                ID_EX_Branch    <= 1'b0;
                ID_EX_MemRead   <= 1'b0;
                ID_EX_MemtoReg  <= 1'b0;
                ID_EX_MemWrite  <= 1'b0;
                ID_EX_ALUSrc    <= 1'b0;
                ID_EX_RegWrite  <= 1'b0;
                if (Bubble_Count != BUBBLE_SAT)
                    Bubble_Count <= Bubble_Count + 16'd1;
            end else begin
                ID_EX_RS1       <= IF_ID_RS1;
                ID_EX_RS2       <= IF_ID_RS2;
                ID_EX_RD        <= IF_ID_RD;
                ID_EX_ALUOp     <= ALUOp;
                ID_EX_Branch    <= Branch;
                ID_EX_MemRead   <= MemRead;
                ID_EX_MemtoReg  <= MemtoReg;
                ID_EX_MemWrite  <= MemWrite;
                ID_EX_ALUSrc    <= ALUSrc;
                ID_EX_RegWrite  <= RegWrite;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a stage-level model of the ID/EX register.
// The bubble counter saturation limit is lowered so saturation is reachable quickly.
module tb_id_ex_stage;

    localparam logic [15:0] SAT = 16'd48;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  f4;
        logic [1:0]  aluop;
        logic        br, mr, m2r, mw, as, rw;
    } st_t;

    logic clk, reset, flush;
    st_t  in;
    st_t  dut_o;
    st_t  m;
    int   cnt;
    int   checks, failures;

    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [63:0] o_pc, o_rd1, o_rd2, o_imm;
    logic [3:0]  o_f4;
    logic [1:0]  o_aluop;
    logic        o_br, o_mr, o_m2r, o_mw, o_as, o_rw;
    logic        pc_write, if_id_write;
    logic [15:0] bubble_count;

    assign dut_o = {o_rs1, o_rs2, o_rd, o_pc, o_rd1, o_rd2, o_imm, o_f4, o_aluop,
                    o_br, o_mr, o_m2r, o_mw, o_as, o_rw};

    id_ex_stage #(.BUBBLE_SAT(SAT)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RS1(in.rs1), .IF_ID_RS2(in.rs2), .IF_ID_RD(in.rd),
        .IF_ID_PC(in.pc), .ReadData1(in.rd1), .ReadData2(in.rd2), .Imm(in.imm),
        .Funct4(in.f4), .Branch(in.br), .MemRead(in.mr), .MemtoReg(in.m2r),
        .MemWrite(in.mw), .ALUSrc(in.as), .RegWrite(in.rw), .ALUOp(in.aluop),
        .Flush(flush),
        .ID_EX_RS1(o_rs1), .ID_EX_RS2(o_rs2), .ID_EX_RD(o_rd), .ID_EX_PC(o_pc),
        .ID_EX_ReadData1(o_rd1), .ID_EX_ReadData2(o_rd2), .ID_EX_Imm(o_imm),
        .ID_EX_Funct4(o_f4), .ID_EX_ALUOp(o_aluop), .ID_EX_Branch(o_br),
        .ID_EX_MemRead(o_mr), .ID_EX_MemtoReg(o_m2r), .ID_EX_MemWrite(o_mw),
        .ID_EX_ALUSrc(o_as), .ID_EX_RegWrite(o_rw),
        .PC_Write(pc_write), .IF_ID_Write(if_id_write), .Bubble_Count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mr);
        st_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.pc  = {$urandom, $urandom}; s.rd1 = {$urandom, $urandom};
        s.rd2 = {$urandom, $urandom}; s.imm = {$urandom, $urandom};
        s.f4  = 4'($urandom); s.aluop = 2'($urandom);
        s.br  = 1'($urandom); s.mr = mr; s.m2r = 1'($urandom);
        s.mw  = 1'($urandom); s.as = 1'($urandom); s.rw = 1'($urandom);
        return s;
    endfunction

    // Load-use rule applied to what the model says is sitting in ID/EX.
    function automatic logic model_hazard();
        return m.mr && (m.rd != 0) && ((m.rd == in.rs1) || (m.rd == in.rs2));
    endfunction

    function automatic st_t model_next(input st_t i, input logic fl, input logic hz);
        st_t n;
        if (fl) return '0;
        n = i;
        if (hz) begin
            n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.aluop = 0;
            n.br = 0; n.mr = 0; n.m2r = 0; n.mw = 0; n.as = 0; n.rw = 0;
        end
        return n;
    endfunction

    task automatic tick();
        logic hz;
        hz = model_hazard();
        @(posedge clk);
        m = model_next(in, flush, hz);
        if (hz && !flush && cnt < int'(SAT)) cnt++;
        #1;
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        reset = 1'b1;
        m = '0;
        cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0;
        in = mk(5'd3, 5'd4, 5'd3, 1'b1);
        #2;
        checks++;
        if (dut_o !== st_t'('0) || bubble_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_initial: outputs=%h count=%0d, required all zero", dut_o, bubble_count);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_o !== st_t'('0) || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++;
            $display("FAIL reset_held: outputs=%h pc_write=%b if_id_write=%b, required zero/1/1",
                     dut_o, pc_write, if_id_write);
        end
        do_reset_release();
    endtask

    task automatic test_pass_through();
        in = mk(5'd1, 5'd2, 5'd5, 1'b0);
        in.rw = 1'b1; in.rd1 = 64'hA5;
        tick();
        checks++;
        if (o_rd !== 5'd5 || o_rw !== 1'b1 || o_rd1 !== 64'hA5 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL pass_through: rd=%0d rw=%b rd1=%h pc_write=%b, required 5/1/a5/1",
                     o_rd, o_rw, o_rd1, pc_write);
        end
        checks++;
        if (dut_o !== m) begin
            failures++;
            $display("FAIL pass_through_all: got %h, required %h", dut_o, m);
        end
    endtask

    task automatic test_load_use();
        int c0;
        c0 = cnt;
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        in = mk(5'd6, 5'd9, 5'd10, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
            failures++;
            $display("FAIL load_use_stall: pc_write=%b if_id_write=%b, required 0/0", pc_write, if_id_write);
        end
        tick();
        checks++;
        if ({o_br, o_mr, o_m2r, o_mw, o_as, o_rw, o_aluop} !== 8'd0 || o_rd !== 5'd0 ||
            o_rs1 !== 5'd0 || o_rs2 !== 5'd0 || bubble_count !== 16'(c0 + 1)) begin
            failures++;
            $display("FAIL load_use_bubble: ctrl=%b%b%b%b%b%b aluop=%0d rs1=%0d rs2=%0d rd=%0d count=%0d, required zeros count=%0d",
                     o_br, o_mr, o_m2r, o_mw, o_as, o_rw, o_aluop, o_rs1, o_rs2, o_rd, bubble_count, c0 + 1);
        end
        checks++;
        if (pc_write !== 1'b1) begin
            failures++;
            $display("FAIL load_use_release: pc_write=%b, required 1", pc_write);
        end
        tick();
        checks++;
        if (o_rs1 !== 5'd6 || o_rd !== 5'd10 || dut_o !== m || bubble_count !== 16'(c0 + 1)) begin
            failures++;
            $display("FAIL load_use_replay: got %h count=%0d, required %h count=%0d",
                     dut_o, bubble_count, m, c0 + 1);
        end
    endtask

    task automatic test_no_false_stall();
        int c0;
        c0 = cnt;
        in = mk(5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        in = mk(5'd0, 5'd0, 5'd3, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            failures++;
            $display("FAIL no_stall_x0: pc_write=%b, required 1", pc_write);
        end
        tick();
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        in = mk(5'd7, 5'd8, 5'd3, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++;
            $display("FAIL no_stall_unrelated: pc_write=%b if_id_write=%b, required 1/1", pc_write, if_id_write);
        end
        tick();
        checks++;
        if (bubble_count !== 16'(c0) || dut_o !== m) begin
            failures++;
            $display("FAIL no_stall_count: count=%0d out=%h, required count=%0d out=%h",
                     bubble_count, dut_o, c0, m);
        end
    endtask

    task automatic test_both_match();
        int c0;
        c0 = cnt;
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        in = mk(5'd6, 5'd6, 5'd4, 1'b0);
        tick();
        tick();
        checks++;
        if (bubble_count !== 16'(c0 + 1) || o_rs1 !== 5'd6 || o_rs2 !== 5'd6 || dut_o !== m) begin
            failures++;
            $display("FAIL both_match_one_bubble: count=%0d out=%h, required count=%0d out=%h",
                     bubble_count, dut_o, c0 + 1, m);
        end
    endtask

    task automatic test_flush_priority();
        int c0;
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        c0 = cnt;
        in = mk(5'd6, 5'd2, 5'd4, 1'b1);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++;
            $display("FAIL flush_release: pc_write=%b if_id_write=%b, required 1/1", pc_write, if_id_write);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (dut_o !== st_t'('0) || bubble_count !== 16'(c0)) begin
            failures++;
            $display("FAIL flush_zero: out=%h count=%0d, required zero count=%0d", dut_o, bubble_count, c0);
        end
    endtask

    task automatic test_async_reset();
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_o !== st_t'('0) || bubble_count !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: out=%h count=%0d, required zero", dut_o, bubble_count);
        end
        do_reset_release();
        in = mk(5'd1, 5'd2, 5'd6, 1'b1);
        tick();
        in = mk(5'd6, 5'd3, 5'd7, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_stall_write: pc_write=%b if_id_write=%b, required 1/1", pc_write, if_id_write);
        end
        do_reset_release();
        tick();
        checks++;
        if (o_rs1 !== 5'd6 || dut_o !== m || bubble_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_no_pending_bubble: out=%h count=%0d, required %h count=0",
                     dut_o, bubble_count, m);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < int'(SAT) + 4; i++) begin
            in = mk(5'd0, 5'd0, 5'd6, 1'b1);
            tick();
            in = mk(5'd6, 5'd1, 5'd2, 1'b0);
            tick();
        end
        checks++;
        if (bubble_count !== SAT || cnt != int'(SAT)) begin
            failures++;
            $display("FAIL saturation: count=%0d, required %0d", bubble_count, SAT);
        end
        in = mk(5'd0, 5'd0, 5'd6, 1'b1);
        tick();
        in = mk(5'd1, 5'd6, 5'd2, 1'b0);
        #1;
        checks++;
        if (pc_write !== 1'b0) begin
            failures++;
            $display("FAIL saturation_still_stalls: pc_write=%b, required 0", pc_write);
        end
        tick();
        checks++;
        if (bubble_count !== SAT || o_mr !== 1'b0) begin
            failures++;
            $display("FAIL saturation_hold: count=%0d memread=%b, required %0d/0", bubble_count, o_mr, SAT);
        end
    endtask

    task automatic test_random();
        logic exp_w;
        do_reset_release_async();
        for (int i = 0; i < 300; i++) begin
            in = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 9) == 0);
            #1;
            exp_w = !model_hazard() || flush;
            checks++;
            if (pc_write !== exp_w || if_id_write !== exp_w) begin
                failures++;
                $display("FAIL random_write[%0d]: pc_write=%b if_id_write=%b, required %b", i, pc_write, if_id_write, exp_w);
            end
            tick();
            checks++;
            if (dut_o !== m || bubble_count !== 16'(cnt)) begin
                failures++;
                $display("FAIL random_state[%0d]: out=%h count=%0d, required %h count=%0d",
                         i, dut_o, bubble_count, m, cnt);
            end
        end
        flush = 1'b0;
    endtask

    task automatic do_reset_release_async();
        #2;
        reset = 1'b0;
        do_reset_release();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cnt = 0;
        m = '0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_both_match();
        test_flush_priority();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
